// File: rtl/ram_capture_ctrl.sv
// Capture RAM sequencer: arms on an edge pulse, fills the RAM with samples,
// then streams the stored words back out over a valid/ready handshake.
module ram_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_edge,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_dump,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_re,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_full_mem_indicator,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_FULL,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              we, re;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (i_abort) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_data_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_edge) begin
            state_d  = S_CAPTURE;
            wr_ptr_d = '0;
          end
        end
        S_CAPTURE: begin
          if (i_sample_valid) begin
            wr_ptr_d = wr_ptr_q + ONE;
            if (wr_ptr_q == LAST) state_d = S_FULL;
          end
        end
        S_FULL: begin
          if (i_dump) begin
            state_d  = S_RD_REQ;
            rd_ptr_d = '0;
          end
        end
        S_RD_REQ: state_d = S_RD_WAIT;
        S_RD_WAIT: begin
          rd_data_d = i_ram_rdata;
          state_d   = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (i_rd_ready) begin
            if (rd_ptr_q == LAST) begin
              // Last word consumed: leave every output at 0 in IDLE.
              state_d   = S_IDLE;
              rd_data_d = '0;
            end else begin
              rd_ptr_d = rd_ptr_q + ONE;
              state_d  = S_RD_REQ;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign we = (state_q == S_CAPTURE) && i_sample_valid;
  assign re = (state_q == S_RD_REQ);

  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (we) begin
      o_ram_addr  = wr_ptr_q;
      o_ram_wdata = i_sample;
    end else if (re) begin
      o_ram_addr = rd_ptr_q;
    end
  end

  assign o_ram_we   = we;
  assign o_ram_re   = re;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = (state_q == S_RD_HOLD);

  assign o_full_mem_indicator = (state_q == S_FULL)    ||
                                (state_q == S_RD_REQ)  ||
                                (state_q == S_RD_WAIT) ||
                                (state_q == S_RD_HOLD);

  assign o_busy = (state_q == S_CAPTURE) ||
                  (state_q == S_RD_REQ)  ||
                  (state_q == S_RD_WAIT) ||
                  (state_q == S_RD_HOLD);

endmodule
